imem_loader: RTL



---
 rtl/imem_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: decodes a length-prefixed frame, writes little-endian
// 32-bit words to imem from index 0, and checks a trailing XOR checksum.
module imem_loader #(
  parameter int IMEM_DEPTH = 256,
  localparam int ADDR_WIDTH = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  state_t        state_r;
  logic [15:0]   len_r;
  logic [1:0]    lane_r;
  logic [23:0]   word_r;
  logic [7:0]    csum_r;
  logic          busy_r;

  logic          accept_s;
  logic [15:0]   len_full_s;
  logic [16:0]   next_count_s;
  logic          last_word_s;
  logic          overflow_s;

  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Byte handshake qualifiers and length/count comparisons.
  always_comb begin
    accept_s     = in_valid && busy_r;
    len_full_s   = {in_data, len_r[7:0]};
    next_count_s = 17'(words_written) + 17'd1;
    last_word_s  = (next_count_s == {1'b0, len_r});
    overflow_s   = ({1'b0, len_full_s} > 17'(IMEM_DEPTH));
  end

  assign busy     = busy_r;
  assign in_ready = busy_r;

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      busy_r        <= 1'b0;
      len_r         <= 16'd0;
      lane_r        <= 2'd0;
      word_r        <= 24'd0;
      csum_r        <= 8'd0;
      imem_we       <= 1'b0;
      imem_waddr    <= '0;
      imem_wdata    <= 32'd0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state_r)
        IDLE, DONE, ERR: begin
          if (start) begin
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            lane_r        <= 2'd0;
            csum_r        <= 8'd0;
            busy_r        <= 1'b1;
            state_r       <= LEN0;
          end else begin
            state_r <= IDLE;
          end
        end
        LEN0: begin
          if (accept_s) begin
            len_r[7:0] <= in_data;
            state_r    <= LEN1;
          end
        end
        LEN1: begin
          if (accept_s) begin
            len_r[15:8] <= in_data;
            if (overflow_s) begin
              error   <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= ERR;
            end else if (len_full_s == 16'd0) begin
              state_r <= CSUM;
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_s) begin
            csum_r <= csum_next(csum_r, in_data);
            lane_r <= lane_r + 2'd1;
            word_r <= {in_data, word_r[23:8]};
            // Lane 3 completes the word; earlier bytes already sit in word_r[23:0].
            if (lane_r == 2'd3) begin
              imem_we       <= 1'b1;
              imem_waddr    <= words_written[ADDR_WIDTH-1:0];
              imem_wdata    <= {in_data, word_r};
              words_written <= next_count_s[ADDR_WIDTH:0];
              if (last_word_s) begin
                state_r <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (accept_s) begin
            busy_r <= 1'b0;
            if (in_data == csum_r) begin
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              error   <= 1'b1;
              state_r <= ERR;
            end
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
